bcd_to_bin_entry: RTL and testbench
===================================

BCD_TO_BIN_ENTRY -- requirements
Module: bcd_to_bin_entry

Interface
REQ-001 The block SHALL have parameter START_EDGE, default 0; 0 = start is level-sampled in IDLE, 1 = only a rising edge of start (registered previous value) initiates a conversion.
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port KEY0, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, conversion request.
REQ-005 The block SHALL have port bcd_dezena, input, 4 bits, tens digit.
REQ-006 The block SHALL have port bcd_unidade, input, 4 bits, units digit.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, single-cycle completion pulse.
REQ-009 The block SHALL have port bin, output, 7 bits, binary result 0..99.
REQ-010 The block SHALL have port err, output, 1 bit, invalid-digit flag for the last request.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE, on the edge (N) that accepts start, the block SHALL capture {bcd_dezena, bcd_unidade} into an 8-bit BCD register, clear a 7-bit work register and a 3-bit iteration counter, and go to SHIFT.
REQ-013 Each SHIFT edge SHALL shift {BCD, work} right by one bit as a 15-bit value, then subtract 3 from each BCD nibble whose value is >= 8 (reverse double-dabble).
REQ-014 After the 7th SHIFT iteration (edge N+7), the block SHALL load bin from the work register and enter DONE; done SHALL be high for exactly the cycle following edge N+7.
REQ-015 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-016 busy SHALL be high after edge N and low after edge N+7; busy and done SHALL never be high together.
REQ-017 start SHALL be ignored in SHIFT and DONE; with START_EDGE=0, start held high SHALL begin a new conversion on the first IDLE edge after DONE.
REQ-018 bin and err SHALL hold their values from done until the next done; digit inputs SHALL affect nothing except at capture.
REQ-019 For valid digits d, u (0..9) the block SHALL produce bin = 10*d + u.

Reset
REQ-020 While KEY0=0, the block SHALL force state=IDLE, busy=0, done=0, bin=0, err=0, counter=0, and the edge-detect register=0, independent of the clock.
REQ-021 Reset asserted mid-SHIFT SHALL abort the conversion; no done pulse SHALL follow release.
REQ-022 The first possible acceptance after reset release SHALL be the first rising edge with KEY0=1.

Configuration
REQ-023 Macro BCD_RANGE_CHECK_EN defined: at capture, if either digit > 9, the block SHALL skip SHIFT, go directly to DONE (done high in the cycle after edge N+1), and set bin=0, err=1; valid requests SHALL set err=0.
REQ-024 Macro BCD_RANGE_CHECK_EN undefined: err SHALL be constant 0, all requests SHALL take the SHIFT path, and bin for invalid digits SHALL be deterministic but unspecified.

Verification
REQ-025 Test d=9, u=9 with start pulse at edge N -> busy high for 7 cycles, done at edge N+7, bin=99, err=0.
REQ-026 Test d=0, u=0, then d=4, u=2 -> bin=0, then bin=42; a start pulse at edge N+3 of the second request SHALL cause no extra done.
REQ-027 Test KEY0 low at edge N+4 of a d=7, u=5 conversion, then release -> outputs all 0, no done pulse, next request d=7, u=5 SHALL give bin=75.
REQ-028 Test (BCD_RANGE_CHECK_EN) d=1, u=12 -> done after edge N+1, bin=0, err=1; next request d=1, u=2 -> bin=12, err=0.
REQ-029 Test START_EDGE=1 with start held high for 30 cycles, d=3, u=8 -> exactly one done, bin=38; START_EDGE=0 with the same stimulus -> a done every 9 cycles.

Source files
------------

// File: rtl/bcd_to_bin_entry.sv
// bcd_to_bin_entry: two-digit BCD to 7-bit binary converter using reverse
// double-dabble. A conversion takes seven shift cycles, then one done cycle.
// START_EDGE = 0 accepts start as a level in IDLE; 1 accepts only its rising edge.
// Optional feature macro: BCD_RANGE_CHECK_EN. When it is defined, a request
// with a digit above 9 takes a one-cycle path to DONE and reports bin=0, err=1.
//
// state | meaning
// IDLE  | waiting for an accepted start; outputs hold the last result
// SHIFT | one reverse double-dabble iteration per cycle (busy high)
// DONE  | result valid, done high for this single cycle
module bcd_to_bin_entry #(
  parameter int START_EDGE = 0
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       start,
  input  logic [3:0] bcd_dezena,
  input  logic [3:0] bcd_unidade,
  output logic       busy,
  output logic       done,
  output logic [6:0] bin,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_nxt;
  logic [7:0]  bcd_q, bcd_nxt;
  logic [6:0]  work_q, work_nxt;
  logic [2:0]  cnt_q, cnt_nxt;
  logic [6:0]  bin_q, bin_nxt;
  logic        start_q;
  logic        accept;
  logic [14:0] shifted;
  logic [3:0]  hi_sh, lo_sh;
  logic [7:0]  bcd_fix;

`ifdef BCD_RANGE_CHECK_EN
  logic        inv_q, inv_nxt;
  logic        err_q, err_nxt;
`endif

  // Level or rising-edge qualification of the request.
  assign accept = (START_EDGE != 0) ? (start & ~start_q) : start;

  // One iteration: shift {bcd, work} right, then correct nibbles that reached 8.
  assign shifted = {bcd_q, work_q} >> 1;
  assign hi_sh   = shifted[14:11];
  assign lo_sh   = shifted[10:7];
  assign bcd_fix = {(hi_sh >= 4'd8) ? (hi_sh - 4'd3) : hi_sh,
                    (lo_sh >= 4'd8) ? (lo_sh - 4'd3) : lo_sh};

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_nxt = state_q;
    bcd_nxt   = bcd_q;
    work_nxt  = work_q;
    cnt_nxt   = cnt_q;
    bin_nxt   = bin_q;
`ifdef BCD_RANGE_CHECK_EN
    inv_nxt   = inv_q;
    err_nxt   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          bcd_nxt   = {bcd_dezena, bcd_unidade};
          work_nxt  = '0;
          cnt_nxt   = '0;
`ifdef BCD_RANGE_CHECK_EN
          inv_nxt   = (bcd_dezena > 4'd9) || (bcd_unidade > 4'd9);
`endif
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
`ifdef BCD_RANGE_CHECK_EN
        if (inv_q) begin
          bin_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else
`endif
        begin
          bcd_nxt  = bcd_fix;
          work_nxt = shifted[6:0];
          cnt_nxt  = cnt_q + 3'd1;
          if (cnt_q == 3'd6) begin
            bin_nxt   = shifted[6:0];
`ifdef BCD_RANGE_CHECK_EN
            err_nxt   = 1'b0;
`endif
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Datapath registers and start edge-detect history.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      bcd_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      start_q <= 1'b0;
`ifdef BCD_RANGE_CHECK_EN
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      bcd_q   <= bcd_nxt;
      work_q  <= work_nxt;
      cnt_q   <= cnt_nxt;
      bin_q   <= bin_nxt;
      start_q <= start;
`ifdef BCD_RANGE_CHECK_EN
      inv_q   <= inv_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bin  = bin_q;
`ifdef BCD_RANGE_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_entry.sv
// Directed and randomized bench for bcd_to_bin_entry; one instance per
// START_EDGE setting, sharing clock, reset and digit inputs.
module tb_bcd_to_bin_entry;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] dz = '0, un = '0;
  logic       busy0, done0, err0, busy1, done1, err1;
  logic [6:0] bin0, bin1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_to_bin_entry #(.START_EDGE(0)) dut0 (
    .CLOCK_50(clk), .KEY0(rst_n), .start(start0),
    .bcd_dezena(dz), .bcd_unidade(un),
    .busy(busy0), .done(done0), .bin(bin0), .err(err0)
  );

  bcd_to_bin_entry #(.START_EDGE(1)) dut1 (
    .CLOCK_50(clk), .KEY0(rst_n), .start(start1),
    .bcd_dezena(dz), .bcd_unidade(un),
    .busy(busy1), .done(done1), .bin(bin1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int inst);
    return (inst != 0) ? busy1 : busy0;
  endfunction
  function automatic logic get_done(input int inst);
    return (inst != 0) ? done1 : done0;
  endfunction
  function automatic logic [6:0] get_bin(input int inst);
    return (inst != 0) ? bin1 : bin0;
  endfunction
  function automatic logic get_err(input int inst);
    return (inst != 0) ? err1 : err0;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst != 0) start1 = v;
    else           start0 = v;
  endtask

  // One request; call just after a negedge. Edge N is the next posedge.
  // Sample j is taken at the negedge following edge N+j.
  task automatic conv(input int inst, input int d, input int u, input int lat,
                      input bit chk_bin, input int exp_bin, input int exp_err,
                      input int pulse_at);
    dz = 4'(d);
    un = 4'(u);
    set_start(inst, 1'b1);
    @(posedge clk);
    for (int j = 0; j <= lat + 2; j++) begin
      @(negedge clk);
      chk("busy",  32'(get_busy(inst)), 32'(j < lat));
      chk("done",  32'(get_done(inst)), 32'(j == lat));
      chk("excl",  32'(get_busy(inst) & get_done(inst)), 32'd0);
      if (j == lat) begin
        if (chk_bin) chk("bin", 32'(get_bin(inst)), 32'(exp_bin));
        chk("err", 32'(get_err(inst)), 32'(exp_err));
      end
      if (j == lat + 2 && chk_bin) chk("bin_hold", 32'(get_bin(inst)), 32'(exp_bin));
      if (j == 0) begin
        set_start(inst, 1'b0);
        dz = 4'($urandom);
        un = 4'($urandom);
      end
      if (j == pulse_at - 1) set_start(inst, 1'b1);
      if (j == pulse_at)     set_start(inst, 1'b0);
    end
  endtask

  initial begin
    int last0, n0, n1, d, u;

    // Reset state, with a request pending that must be ignored.
    start0 = 1'b1;
    #1;
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_bin0",  32'(bin0),  0);
    chk("rst_err0",  32'(err0),  0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_bin1",  32'(bin1),  0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_busy0", 32'(busy0), 0);
    rst_n = 1'b1;

    // First edge after release accepts: 99.
    conv(0, 9, 9, 7, 1, 99, 0, -5);

    // 00 then 42 with a stray start pulse at edge N+3.
    conv(0, 0, 0, 7, 1, 0, 0, -5);
    conv(0, 4, 2, 7, 1, 42, 0, 3);

    // Reset at edge N+4 of a 75 conversion aborts it.
    dz = 4'd7; un = 4'd5; start0 = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) start0 = 1'b0;
      if (j == 3) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_done", 32'(done0), 0);
    chk("abort_bin",  32'(bin0),  0);
    chk("abort_err",  32'(err0),  0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done0 || busy0) n0++;
    end
    chk("abort_no_done", 32'(n0), 0);
    conv(0, 7, 5, 7, 1, 75, 0, -5);

`ifdef BCD_RANGE_CHECK_EN
    conv(0, 1, 12, 1, 1, 0, 1, -5);
    conv(0, 1, 2, 7, 1, 12, 0, -5);
    conv(1, 1, 12, 1, 1, 0, 1, -5);
`else
    conv(0, 1, 12, 7, 0, 0, 0, -5);
    conv(0, 1, 2, 7, 1, 12, 0, -5);
`endif

    // Start held 30 cycles on both instances.
    @(negedge clk);
    dz = 4'd3; un = 4'd8; start0 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    last0 = -1; n0 = 0; n1 = 0;
    for (int j = 0; j < 42; j++) begin
      @(negedge clk);
      if (j == 29) begin start0 = 1'b0; start1 = 1'b0; end
      if (done0 && j < 30) begin
        n0++;
        chk("lvl_bin", 32'(bin0), 38);
        if (last0 < 0) chk("lvl_first", 32'(j), 7);
        else           chk("lvl_period", 32'(j - last0), 9);
        last0 = j;
      end
      if (done1) begin
        n1++;
        chk("edge_bin", 32'(bin1), 38);
      end
    end
    chk("lvl_count", 32'(n0), 3);
    chk("edge_count", 32'(n1), 1);

    // Randomized valid digits against 10*d+u.
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(9));
      u = int'($urandom_range(9));
      conv(i & 1, d, u, 7, 1, 10 * d + u, 0, -5);
    end

    // Randomized invalid tens digit.
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(15, 10));
      u = int'($urandom_range(15));
`ifdef BCD_RANGE_CHECK_EN
      conv(i & 1, d, u, 1, 1, 0, 1, -5);
`else
      conv(i & 1, d, u, 7, 0, 0, 0, -5);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
